// File: rtl/mem_stage_ctrl_if.sv
// Purpose : bundles the EX/MEM request, memory port and MEM/WB result signals of mem_stage_ctrl.
// Ports   : ex* request (master->slave), mem* strobes/address/data plus memReady/memRData,
//           hazard, wb* result, err* sticky flags. The slave modport is the controller side.
interface mem_stage_ctrl_if;
  // EX/MEM request
  logic        exValid;
  logic        exMemRead;
  logic        exMemWrite;
  logic [15:0] exAluOut;
  logic [15:0] exStoreData;
  logic [15:0] exR0;
  logic [3:0]  exDest;

  // memory port
  logic [15:0] memAddr;
  logic [15:0] memWData;
  logic        memRd;
  logic        memWr;
  logic        memReady;
  logic [15:0] memRData;

  // pipeline control and MEM/WB result
  logic        hazard;
  logic        wbValid;
  logic [15:0] wbAluOut;
  logic [15:0] wbData;
  logic [15:0] wbR0;
  logic [3:0]  wbDest;
  logic        wbRegWrite;
  logic        errIllegal;
  logic        errTimeout;

  // upstream stage plus memory model side
  modport master (
    output exValid, exMemRead, exMemWrite, exAluOut, exStoreData, exR0, exDest,
    output memReady, memRData,
    input  memAddr, memWData, memRd, memWr,
    input  hazard, wbValid, wbAluOut, wbData, wbR0, wbDest, wbRegWrite,
    input  errIllegal, errTimeout
  );

  // controller side
  modport slave (
    input  exValid, exMemRead, exMemWrite, exAluOut, exStoreData, exR0, exDest,
    input  memReady, memRData,
    output memAddr, memWData, memRd, memWr,
    output hazard, wbValid, wbAluOut, wbData, wbR0, wbDest, wbRegWrite,
    output errIllegal, errTimeout
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Purpose : MEM pipeline stage controller: passes ALU ops to MEM/WB, runs loads/stores on a ready-handshaked memory.
// Latency : ALU op 1 cycle; load/store 1 + (memory wait) + 1 response cycle; aborts after TIMEOUT wait cycles.
// Backpr. : hazard=1 stalls upstream while an access is outstanding; exValid is ignored in ACCESS and RESP.
// Ports   : clk, reset (async, active-high), bus (mem_stage_ctrl_if.slave). All outputs are registered.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  mem_stage_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // The counter value seen in the last allowed wait cycle; a wait in that
  // cycle without memReady makes the count reach TIMEOUT and aborts.
  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_t      state_q,        state_d;
  logic [3:0]  cnt_q,          cnt_d;

  // instruction latched on acceptance
  logic        ld_q,           ld_d;
  logic [15:0] alu_q,          alu_d;
  logic [15:0] r0_q,           r0_d;
  logic [3:0]  dest_q,         dest_d;

  // registered outputs
  logic [15:0] mem_addr_q,     mem_addr_d;
  logic [15:0] mem_wdata_q,    mem_wdata_d;
  logic        mem_rd_q,       mem_rd_d;
  logic        mem_wr_q,       mem_wr_d;
  logic        hazard_q,       hazard_d;
  logic        wb_vld_q,       wb_vld_d;
  logic [15:0] wb_alu_q,       wb_alu_d;
  logic [15:0] wb_data_q,      wb_data_d;
  logic [15:0] wb_r0_q,        wb_r0_d;
  logic [3:0]  wb_dest_q,      wb_dest_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic        err_illegal_q,  err_illegal_d;
  logic        err_timeout_q,  err_timeout_d;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ld_d           = ld_q;
    alu_d          = alu_q;
    r0_d           = r0_q;
    dest_d         = dest_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_rd_d       = mem_rd_q;
    mem_wr_d       = mem_wr_q;
    hazard_d       = hazard_q;
    wb_vld_d       = 1'b0;            // single-cycle pulse
    wb_alu_d       = wb_alu_q;
    wb_data_d      = wb_data_q;
    wb_r0_d        = wb_r0_q;
    wb_dest_d      = wb_dest_q;
    wb_reg_write_d = wb_reg_write_q;
    err_illegal_d  = err_illegal_q;
    err_timeout_d  = err_timeout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.exValid) begin
          ld_d   = bus.exMemRead;
          alu_d  = bus.exAluOut;
          r0_d   = bus.exR0;
          dest_d = bus.exDest;
          unique case ({bus.exMemRead, bus.exMemWrite})
            2'b00: begin
              // ALU result goes straight to MEM/WB
              wb_vld_d       = 1'b1;
              wb_reg_write_d = 1'b1;
              wb_alu_d       = bus.exAluOut;
              wb_data_d      = bus.exAluOut;
              wb_r0_d        = bus.exR0;
              wb_dest_d      = bus.exDest;
            end
            2'b11: begin
              err_illegal_d  = 1'b1;
            end
            default: begin
              state_d    = ACCESS;
              cnt_d      = 4'd0;
              mem_addr_d = bus.exAluOut;
              if (bus.exMemWrite) begin
                mem_wdata_d = bus.exStoreData;
              end
              mem_rd_d   = bus.exMemRead;
              mem_wr_d   = bus.exMemWrite;
              hazard_d   = 1'b1;
            end
          endcase
        end
      end

      ACCESS: begin
        // memReady takes priority over the timeout check in the same cycle
        if (bus.memReady) begin
          state_d        = RESP;
          cnt_d          = 4'd0;
          mem_rd_d       = 1'b0;
          mem_wr_d       = 1'b0;
          hazard_d       = 1'b0;
          wb_vld_d       = 1'b1;
          wb_reg_write_d = ld_q;
          wb_alu_d       = alu_q;
          wb_data_d      = ld_q ? bus.memRData : 16'h0000;
          wb_r0_d        = r0_q;
          wb_dest_d      = dest_q;
        end else if (cnt_q == CNT_LAST) begin
          // abort: instruction dropped, MEM/WB outputs keep their old values
          state_d        = IDLE;
          cnt_d          = 4'd0;
          mem_rd_d       = 1'b0;
          mem_wr_d       = 1'b0;
          hazard_d       = 1'b0;
          err_timeout_d  = 1'b1;
        end else begin
          cnt_d          = cnt_q + 4'd1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Every output is a flop with async reset, so reset clears strobes and
  // hazard immediately without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      ld_q           <= 1'b0;
      alu_q          <= 16'h0000;
      r0_q           <= 16'h0000;
      dest_q         <= 4'd0;
      mem_addr_q     <= 16'h0000;
      mem_wdata_q    <= 16'h0000;
      mem_rd_q       <= 1'b0;
      mem_wr_q       <= 1'b0;
      hazard_q       <= 1'b0;
      wb_vld_q       <= 1'b0;
      wb_alu_q       <= 16'h0000;
      wb_data_q      <= 16'h0000;
      wb_r0_q        <= 16'h0000;
      wb_dest_q      <= 4'd0;
      wb_reg_write_q <= 1'b0;
      err_illegal_q  <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ld_q           <= ld_d;
      alu_q          <= alu_d;
      r0_q           <= r0_d;
      dest_q         <= dest_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_rd_q       <= mem_rd_d;
      mem_wr_q       <= mem_wr_d;
      hazard_q       <= hazard_d;
      wb_vld_q       <= wb_vld_d;
      wb_alu_q       <= wb_alu_d;
      wb_data_q      <= wb_data_d;
      wb_r0_q        <= wb_r0_d;
      wb_dest_q      <= wb_dest_d;
      wb_reg_write_q <= wb_reg_write_d;
      err_illegal_q  <= err_illegal_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign bus.memAddr    = mem_addr_q;
  assign bus.memWData   = mem_wdata_q;
  assign bus.memRd      = mem_rd_q;
  assign bus.memWr      = mem_wr_q;
  assign bus.hazard     = hazard_q;
  assign bus.wbValid    = wb_vld_q;
  assign bus.wbAluOut   = wb_alu_q;
  assign bus.wbData     = wb_data_q;
  assign bus.wbR0       = wb_r0_q;
  assign bus.wbDest     = wb_dest_q;
  assign bus.wbRegWrite = wb_reg_write_q;
  assign bus.errIllegal = err_illegal_q;
  assign bus.errTimeout = err_timeout_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_mem_stage_ctrl;

  localparam int TO = 15;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;

  mem_stage_ctrl_if bus ();

  mem_stage_ctrl #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // One outstanding memory operation at most; tracked as a record plus a wait count.
  bit          m_busy;
  bit          m_resp;
  int          m_waited;
  bit          m_load;
  logic [15:0] m_alu, m_r0;
  logic [3:0]  m_dest;
  logic [15:0] m_memAddr, m_memWData;
  bit          m_wbValid, m_wbRegWrite, m_errIllegal, m_errTimeout;
  logic [15:0] m_wbAluOut, m_wbData, m_wbR0;
  logic [3:0]  m_wbDest;

  task automatic model_clear();
    m_busy = 0; m_resp = 0; m_waited = 0; m_load = 0;
    m_alu = '0; m_r0 = '0; m_dest = '0;
    m_memAddr = '0; m_memWData = '0;
    m_wbValid = 0; m_wbRegWrite = 0; m_errIllegal = 0; m_errTimeout = 0;
    m_wbAluOut = '0; m_wbData = '0; m_wbR0 = '0; m_wbDest = '0;
  endtask

  task automatic model_publish(input logic [15:0] alu, input logic [15:0] data,
                               input logic [15:0] r0, input logic [3:0] dest, input bit regw);
    m_wbValid = 1; m_wbRegWrite = regw;
    m_wbAluOut = alu; m_wbData = data; m_wbR0 = r0; m_wbDest = dest;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        model_clear();
      end else begin
        m_wbValid = 0;
        if (m_resp) begin
          m_resp = 0;                           // response cycle never accepts work
        end else if (m_busy) begin
          if (bus.memReady) begin
            m_busy = 0;
            m_resp = 1;
            model_publish(m_alu, m_load ? bus.memRData : 16'h0000, m_r0, m_dest, m_load);
          end else begin
            m_waited++;
            if (m_waited == TO) begin
              m_busy = 0;
              m_errTimeout = 1;
            end
          end
        end else if (bus.exValid) begin
          if (bus.exMemRead && bus.exMemWrite) begin
            m_errIllegal = 1;
          end else if (!bus.exMemRead && !bus.exMemWrite) begin
            model_publish(bus.exAluOut, bus.exAluOut, bus.exR0, bus.exDest, 1'b1);
          end else begin
            m_busy = 1;
            m_waited = 0;
            m_load = bus.exMemRead;
            m_alu = bus.exAluOut;
            m_r0 = bus.exR0;
            m_dest = bus.exDest;
            m_memAddr = bus.exAluOut;
            if (bus.exMemWrite) m_memWData = bus.exStoreData;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_hazard",     bus.hazard,     m_busy);
      chk("cmp_memRd",      bus.memRd,      m_busy && m_load);
      chk("cmp_memWr",      bus.memWr,      m_busy && !m_load);
      chk("cmp_memAddr",    bus.memAddr,    m_memAddr);
      chk("cmp_memWData",   bus.memWData,   m_memWData);
      chk("cmp_wbValid",    bus.wbValid,    m_wbValid);
      chk("cmp_wbRegWrite", bus.wbRegWrite, m_wbRegWrite);
      chk("cmp_wbAluOut",   bus.wbAluOut,   m_wbAluOut);
      chk("cmp_wbData",     bus.wbData,     m_wbData);
      chk("cmp_wbR0",       bus.wbR0,       m_wbR0);
      chk("cmp_wbDest",     bus.wbDest,     m_wbDest);
      chk("cmp_errIllegal", bus.errIllegal, m_errIllegal);
      chk("cmp_errTimeout", bus.errTimeout, m_errTimeout);
    end
  end

  task automatic idle_inputs();
    bus.exValid = 0; bus.exMemRead = 0; bus.exMemWrite = 0;
    bus.exAluOut = '0; bus.exStoreData = '0; bus.exR0 = '0; bus.exDest = '0;
    bus.memReady = 0; bus.memRData = '0;
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [15:0] alu,
                       input logic [15:0] sd, input logic [15:0] r0, input logic [3:0] dest);
    bus.exValid = 1; bus.exMemRead = rd; bus.exMemWrite = wr;
    bus.exAluOut = alu; bus.exStoreData = sd; bus.exR0 = r0; bus.exDest = dest;
  endtask

  task automatic drop_ex();
    bus.exValid = 0; bus.exMemRead = 0; bus.exMemWrite = 0;
  endtask

  int ready_pct;

  initial begin
    n_checks = 0;
    n_err = 0;
    idle_inputs();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hazard",  bus.hazard,  0);
    chk("rst_wbValid", bus.wbValid, 0);
    chk("rst_memRd",   bus.memRd,   0);
    chk("rst_wbData",  bus.wbData,  0);
    reset = 0;
    tick();

    // ALU pass-through
    issue(0, 0, 16'h1EDF, 16'h0000, 16'h1234, 4'd3);
    tick();
    drop_ex();
    chk("alu_wbValid",    bus.wbValid,    1);
    chk("alu_wbRegWrite", bus.wbRegWrite, 1);
    chk("alu_wbAluOut",   bus.wbAluOut,   16'h1EDF);
    chk("alu_wbData",     bus.wbData,     16'h1EDF);
    chk("alu_wbDest",     bus.wbDest,     4'd3);
    chk("alu_hazard",     bus.hazard,     0);
    tick();
    chk("alu_wbValid_drop", bus.wbValid, 0);
    chk("alu_wbData_hold",  bus.wbData,  16'h1EDF);

    // load with three wait cycles
    issue(1, 0, 16'h0040, 16'h0000, 16'h0BAD, 4'd7);
    tick();
    drop_ex();
    for (int i = 0; i < 4; i++) begin
      chk("ld_hazard",  bus.hazard,  1);
      chk("ld_memRd",   bus.memRd,   1);
      chk("ld_memAddr", bus.memAddr, 16'h0040);
      if (i == 3) begin
        bus.memReady = 1;
        bus.memRData = 16'h7EF3;
      end
      tick();
    end
    bus.memReady = 0;
    chk("ld_wbValid",    bus.wbValid,    1);
    chk("ld_wbData",     bus.wbData,     16'h7EF3);
    chk("ld_wbRegWrite", bus.wbRegWrite, 1);
    chk("ld_wbR0",       bus.wbR0,       16'h0BAD);
    chk("ld_wbDest",     bus.wbDest,     4'd7);
    chk("ld_hazard_end", bus.hazard,     0);
    chk("ld_memRd_end",  bus.memRd,      0);
    tick();
    chk("ld_wbValid_drop", bus.wbValid, 0);

    // store with memReady tied high (ignored while idle)
    bus.memReady = 1;
    issue(0, 1, 16'h0010, 16'h7EF0, 16'h0001, 4'd2);
    tick();
    drop_ex();
    chk("st_memWr",    bus.memWr,    1);
    chk("st_memWData", bus.memWData, 16'h7EF0);
    chk("st_memAddr",  bus.memAddr,  16'h0010);
    tick();
    chk("st_memWr_end",   bus.memWr,      0);
    chk("st_wbValid",     bus.wbValid,    1);
    chk("st_wbRegWrite",  bus.wbRegWrite, 0);
    chk("st_wbData",      bus.wbData,     16'h0000);
    bus.memReady = 0;
    tick();

    // memReady in the last allowed wait cycle wins over the timeout
    issue(1, 0, 16'h0200, 16'h0000, 16'h0000, 4'd9);
    tick();
    drop_ex();
    repeat (TO - 1) tick();
    bus.memReady = 1;
    bus.memRData = 16'h5A5A;
    tick();
    bus.memReady = 0;
    chk("edge_wbValid",    bus.wbValid,    1);
    chk("edge_wbData",     bus.wbData,     16'h5A5A);
    chk("edge_errTimeout", bus.errTimeout, 0);
    tick();

    // timeout
    issue(1, 0, 16'h0300, 16'h0000, 16'h0000, 4'd4);
    tick();
    drop_ex();
    for (int i = 0; i < TO; i++) begin
      chk("to_hazard",  bus.hazard,     1);
      chk("to_errTo",   bus.errTimeout, 0);
      tick();
    end
    chk("to_errTimeout", bus.errTimeout, 1);
    chk("to_hazard_end", bus.hazard,     0);
    chk("to_memRd_end",  bus.memRd,      0);
    chk("to_wbValid",    bus.wbValid,    0);
    tick();
    issue(0, 0, 16'h00AA, 16'h0000, 16'h0000, 4'd5);
    tick();
    drop_ex();
    chk("to_alu_wbValid", bus.wbValid, 1);
    chk("to_alu_wbData",  bus.wbData,  16'h00AA);
    tick();

    // illegal: both flags
    issue(1, 1, 16'h0400, 16'h1111, 16'h0000, 4'd1);
    tick();
    drop_ex();
    chk("ill_errIllegal", bus.errIllegal, 1);
    chk("ill_memRd",      bus.memRd,      0);
    chk("ill_memWr",      bus.memWr,      0);
    chk("ill_wbValid",    bus.wbValid,    0);
    tick();

    // reset during the 2nd access cycle, between edges
    issue(1, 0, 16'h0500, 16'h0000, 16'h0000, 4'd6);
    tick();
    drop_ex();
    tick();
    #2;
    reset = 1;
    #1;
    chk("rma_memRd",      bus.memRd,      0);
    chk("rma_hazard",     bus.hazard,     0);
    chk("rma_errIllegal", bus.errIllegal, 0);
    chk("rma_errTimeout", bus.errTimeout, 0);
    chk("rma_wbData",     bus.wbData,     0);
    @(posedge clk);
    #1;
    reset = 0;
    issue(1, 0, 16'h0600, 16'h0000, 16'h0000, 4'd8);
    tick();
    drop_ex();
    chk("rma_ld_memRd", bus.memRd, 1);
    bus.memReady = 1;
    bus.memRData = 16'hC0DE;
    tick();
    bus.memReady = 0;
    chk("rma_ld_wbValid", bus.wbValid, 1);
    chk("rma_ld_wbData",  bus.wbData,  16'hC0DE);
    tick();

    // randomized traffic
    ready_pct = 50;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int r;
      if (cyc % 256 == 0) begin
        r = $urandom_range(0, 3);
        ready_pct = (r == 0) ? 0 : (r == 1) ? 10 : (r == 2) ? 50 : 100;
      end
      r = $urandom_range(0, 15);
      bus.exValid     = $urandom_range(0, 1);
      bus.exMemRead   = (r >= 6 && r <= 9) || (r == 15 && $urandom_range(0, 19) == 0);
      bus.exMemWrite  = (r >= 10 && r <= 13) || (bus.exMemRead && r == 15);
      bus.exAluOut    = 16'($urandom);
      bus.exStoreData = 16'($urandom);
      bus.exR0        = 16'($urandom);
      bus.exDest      = 4'($urandom);
      bus.memRData    = 16'($urandom);
      bus.memReady    = ($urandom_range(0, 99) < ready_pct);
      if ($urandom_range(0, 199) == 0) begin
        #2;
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
      end else begin
        tick();
      end
    end

    idle_inputs();
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
